// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, one-deep in-flight tracking, predictor hand-off
// and a 2-entry output queue toward decode with redirect (flush) support.
module fetch_unit #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            pd_valid,
  output logic [31:0]     pd_instr,
  output logic [PC_W-1:0] pd_pc,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            out_pred_taken
);

  logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic            if_v_reg, if_kill_reg;
  logic [PC_W-1:0] if_pc_reg;

  logic [31:0]     q_instr_reg [2];
  logic [PC_W-1:0] q_pc_reg    [2];
  logic            q_taken_reg [2];
  logic            rd_ptr_reg, wr_ptr_reg;
  logic [1:0]      count_reg;

  logic            live, mispred, enq, pop, issue;
  logic [PC_W-1:0] seq_pc;
  logic [2:0]      occ_next;

  assign live     = if_v_reg && !if_kill_reg;
  assign seq_pc   = if_pc_reg + PC_W'(4);
  assign mispred  = live && (pred_pc != seq_pc);
  assign enq      = live && !redirect;
  assign pop      = out_valid && out_ready;
  // Occupancy after this cycle; a new request only goes out if its response will fit.
  assign occ_next = {1'b0, count_reg} + {2'b00, enq} - {2'b00, pop};
  assign issue    = !redirect && (occ_next < 3'd2);

  // Gating with rst_n keeps the strobe low during reset without waiting for an edge.
  assign imem_req  = issue && rst_n;
  assign imem_addr = fetch_pc_reg;

  assign pd_valid = live;
  assign pd_instr = imem_rdata;
  assign pd_pc    = if_pc_reg;

  assign out_valid      = (count_reg != 2'd0);
  assign out_instr      = q_instr_reg[rd_ptr_reg];
  assign out_pc         = q_pc_reg[rd_ptr_reg];
  assign out_pred_taken = q_taken_reg[rd_ptr_reg];

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect)
      fetch_pc_next = redirect_pc;
    else if (mispred)
      fetch_pc_next = pred_pc;
    else if (issue)
      fetch_pc_next = fetch_pc_reg + PC_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      if_v_reg     <= 1'b0;
      if_pc_reg    <= '0;
      if_kill_reg  <= 1'b0;
      count_reg    <= 2'd0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      if_v_reg     <= issue;
      if_pc_reg    <= fetch_pc_reg;
      // The sequential request sent alongside a non-sequential prediction is dead on arrival.
      if_kill_reg  <= issue && (mispred || redirect);
      if (redirect) begin
        count_reg  <= 2'd0;
        rd_ptr_reg <= 1'b0;
        wr_ptr_reg <= 1'b0;
      end else begin
        count_reg  <= count_reg + {1'b0, enq} - {1'b0, pop};
        rd_ptr_reg <= rd_ptr_reg ^ pop;
        wr_ptr_reg <= wr_ptr_reg ^ enq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_instr_reg[i] <= '0;
        q_pc_reg[i]    <= '0;
        q_taken_reg[i] <= 1'b0;
      end
    end else if (enq) begin
      q_instr_reg[wr_ptr_reg] <= imem_rdata;
      q_pc_reg[wr_ptr_reg]    <= if_pc_reg;
      q_taken_reg[wr_ptr_reg] <= pred_taken;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table, directed redirect/wrap/reset
// sequences, and a randomized run checked against a program-flow reference.
module tb_fetch_unit;
  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            pd_valid;
  logic [31:0]     pd_instr;
  logic [PC_W-1:0] pd_pc;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            out_pred_taken;
  logic            rand_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pd_valid(pd_valid), .pd_instr(pd_instr), .pd_pc(pd_pc),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pred_taken(out_pred_taken)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] pc);
    return 32'hA5C0_0000 ^ {pc, 12'h000, pc};
  endfunction

  function automatic logic pt_f(input logic [9:0] pc, input logic rm);
    return (pc == 10'h008) || (rm && pc[4:2] == 3'd5);
  endfunction

  function automatic logic [9:0] tgt_f(input logic [9:0] pc, input logic rm);
    return (rm && pc[4:2] == 3'd5) ? {pc[9:5] + 5'd7, 5'd0} : 10'h040;
  endfunction

  // Synchronous instruction memory and combinational predictor.
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);
  assign pred_taken = pt_f(pd_pc, rand_mode);
  assign pred_pc    = pred_taken ? tgt_f(pd_pc, rand_mode) : pd_pc + 10'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [9:0] rp);
    @(negedge clk);
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rp;
    #1;
  endtask

  task automatic chk_out(input string name, input logic [9:0] pc);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_pc"}, {22'd0, out_pc}, {22'd0, pc});
    chk({name, "_instr"}, out_instr, mem_word(pc));
  endtask

  typedef struct {
    logic       ready;
    logic       req;
    logic [9:0] addr;
    logic       ov;
    logic [9:0] opc;
    logic       pdv;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [9:0] exp_pc, prev_pc, rp;
    logic [31:0] prev_instr;
    logic prev_hold, prev_taken, rdy, rd;
    int ntx;

    // Sequential fetch, predicted jump 0x008->0x040, then 6 cycles of backpressure.
    vecs[0]  = '{1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 10'h004, 1'b0, 10'h000, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 10'h008, 1'b1, 10'h000, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 10'h00C, 1'b1, 10'h004, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 10'h040, 1'b1, 10'h008, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 10'h044, 1'b0, 10'h000, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 10'h048, 1'b1, 10'h040, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 10'h04C, 1'b1, 10'h044, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 10'h050, 1'b1, 10'h048, 1'b1};
    for (int i = 9; i < 14; i++)
      vecs[i] = '{1'b0, 1'b0, 10'h050, 1'b1, 10'h048, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 10'h050, 1'b1, 10'h048, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 10'h054, 1'b1, 10'h04C, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 10'h058, 1'b1, 10'h050, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 10'h05C, 1'b1, 10'h054, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {22'd0, imem_addr}, 32'd0);
    chk("rst_out_pc", {22'd0, out_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
      chk($sformatf("v%0d_addr", i), {22'd0, imem_addr}, {22'd0, vecs[i].addr});
      chk($sformatf("v%0d_pdv", i), {31'd0, pd_valid}, {31'd0, vecs[i].pdv});
      chk($sformatf("v%0d_ov", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_pc", i), {22'd0, out_pc}, {22'd0, vecs[i].opc});
        chk($sformatf("v%0d_instr", i), out_instr, mem_word(vecs[i].opc));
      end
      $display("VEC %0d: req=%b addr=%h pd_valid=%b out_valid=%b out_pc=%h",
               i, imem_req, imem_addr, pd_valid, out_valid, out_pc);
    end

    // Redirect to 0x100 while the queue is full.
    step(1'b0, 1'b0, 10'h000); chk("rd0_req", {31'd0, imem_req}, 32'd0); chk_out("rd0", 10'h058);
    step(1'b0, 1'b1, 10'h100); chk("rd1_req", {31'd0, imem_req}, 32'd0); chk_out("rd1", 10'h058);
    step(1'b1, 1'b0, 10'h000);
    chk("rd2_valid", {31'd0, out_valid}, 32'd0);
    chk("rd2_req", {31'd0, imem_req}, 32'd1);
    chk("rd2_addr", {22'd0, imem_addr}, 32'h100);
    step(1'b1, 1'b0, 10'h000);
    chk("rd3_valid", {31'd0, out_valid}, 32'd0);
    chk("rd3_pdpc", {22'd0, pd_pc}, 32'h100);
    step(1'b1, 1'b0, 10'h000); chk_out("rd4", 10'h100);
    step(1'b1, 1'b0, 10'h000); chk_out("rd5", 10'h104);
    $display("SEQ redirect to 0x100 done");

    // Wrap-around from 0x3F8.
    step(1'b1, 1'b1, 10'h3F8);
    step(1'b1, 1'b0, 10'h000);
    chk("wr_valid", {31'd0, out_valid}, 32'd0);
    chk("wr_addr0", {22'd0, imem_addr}, 32'h3F8);
    step(1'b1, 1'b0, 10'h000); chk("wr_addr1", {22'd0, imem_addr}, 32'h3FC);
    step(1'b1, 1'b0, 10'h000); chk_out("wr0", 10'h3F8); chk("wr_addr2", {22'd0, imem_addr}, 32'h000);
    step(1'b1, 1'b0, 10'h000); chk_out("wr1", 10'h3FC);
    step(1'b1, 1'b0, 10'h000); chk_out("wr2", 10'h000);
    step(1'b1, 1'b0, 10'h000); chk_out("wr3", 10'h004);
    $display("SEQ wrap-around done");

    // Fill the queue, then assert reset between clock edges.
    repeat (3) step(1'b0, 1'b0, 10'h000);
    chk_out("full", 10'h008);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pdv", {31'd0, pd_valid}, 32'd0);
    chk("arst_addr", {22'd0, imem_addr}, 32'd0);
    chk("arst_pc", {22'd0, out_pc}, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_taken", {31'd0, out_pred_taken}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", {22'd0, imem_addr}, 32'd0);
    chk("rel_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 1'b0, 10'h000); chk("rel1_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 1'b0, 10'h000); chk_out("rel2", 10'h000);
    step(1'b1, 1'b0, 10'h000); chk_out("rel3", 10'h004);
    $display("SEQ reset mid-operation done");

    // Randomized run: delivered stream must follow program flow from each restart point.
    rand_mode = 1'b1;
    rp = 10'($urandom) & 10'h3FC;
    step(1'b0, 1'b1, rp);
    exp_pc = rp;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    prev_taken = 1'b0;
    ntx = 0;
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 29) == 0);
      rp  = 10'($urandom) & 10'h3FC;
      step(rdy, rd, rp);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_pc", {22'd0, out_pc}, {22'd0, prev_pc});
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_taken", {31'd0, out_pred_taken}, {31'd0, prev_taken});
      end
      if (out_valid && out_ready) begin
        chk("rnd_pc", {22'd0, out_pc}, {22'd0, exp_pc});
        chk("rnd_instr", out_instr, mem_word(exp_pc));
        chk("rnd_taken", {31'd0, out_pred_taken}, {31'd0, pt_f(exp_pc, 1'b1)});
        $display("TXN %0d: pc=%h instr=%h taken=%b", ntx, out_pc, out_instr, out_pred_taken);
        exp_pc = pt_f(exp_pc, 1'b1) ? tgt_f(exp_pc, 1'b1) : exp_pc + 10'd4;
        ntx++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_hold  = out_valid && !out_ready && !redirect;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      prev_taken = out_pred_taken;
    end
    chk("rnd_min_transfers", {31'd0, ntx >= 400}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
